// File: rtl/microseq_ctrl_pkg.sv
// Shared microaddress sequencing types: sequencing ops, counter commands, fault codes.
package microseq_ctrl_pkg;

  localparam int unsigned MICROADDR_W = 11;

  typedef logic [MICROADDR_W-1:0] maddr_t;

  typedef enum logic [2:0] {
    SEQ_NEXT     = 3'd0,
    SEQ_JUMP     = 3'd1,
    SEQ_JCOND    = 3'd2,
    SEQ_CALL     = 3'd3,
    SEQ_RET      = 3'd4,
    SEQ_DISPATCH = 3'd5,
    SEQ_LDCNT    = 3'd6,
    SEQ_DJNZ     = 3'd7
  } seq_op_e;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_INC  = 2'd1,
    CMD_LOAD = 2'd2
  } cmd_e;

  localparam logic [1:0] FAULT_NONE      = 2'd0;
  localparam logic [1:0] FAULT_OVERFLOW  = 2'd1;
  localparam logic [1:0] FAULT_UNDERFLOW = 2'd2;

endpackage

// File: rtl/microseq_stack.sv
// Return-address LIFO for microsubroutine linkage; push/pop ignored when full/empty.
module microseq_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 11
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [W-1:0]                 push_data_i,
  output logic [W-1:0]                 top_o,
  output logic [$clog2(DEPTH+1)-1:0]   sp_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned SP_W = $clog2(DEPTH + 1);

  logic [W-1:0]    mem_q [DEPTH];
  logic [SP_W-1:0] sp_q;

  assign full_o  = (sp_q == SP_W'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign sp_o    = sp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q <= '0;
    end else if (push_i && !full_o) begin
      sp_q <= sp_q + SP_W'(1);
    end else if (pop_i && !empty_o) begin
      sp_q <= sp_q - SP_W'(1);
    end
  end

  // Entries carry no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!reset && push_i && !full_o && (sp_q == SP_W'(i))) begin
        mem_q[i] <= push_data_i;
      end
    end
  end

  always_comb begin
    top_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) begin
        top_o = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/microseq_ctrl.sv
// Next-address controller: decodes the microword sequencing field into NONE/INC/LOAD.
// Optional loop counter ops (LDCNT/DJNZ) enabled by defining MICROSEQ_LOOP_EN.
module microseq_ctrl
  import microseq_ctrl_pkg::*;
#(
  parameter int unsigned STACK_DEPTH    = 4,
  parameter logic [10:0] DISPATCH_BASE  = 11'h400,
  parameter int unsigned DISPATCH_SHIFT = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  seq_op_e                             seq_op,
  input  logic [MICROADDR_W-1:0]              target,
  input  logic [2:0]                          cond_sel,
  input  logic                                cond_inv,
  input  logic [7:0]                          flags,
  input  logic [7:0]                          opcode,
  input  logic                                stall,
  input  logic [MICROADDR_W-1:0]              cur_addr,
  output cmd_e                                cmd,
  output logic [MICROADDR_W-1:0]              load_addr,
  output logic [$clog2(STACK_DEPTH+1)-1:0]    sp,
  output logic                                fault,
  output logic [1:0]                          fault_code
);

  typedef enum logic {ST_RUN = 1'b0, ST_FAULT = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [1:0] fault_code_q, fault_code_d;
  logic       fault_q;

  cmd_e   cmd_c;
  maddr_t load_addr_c;
  logic   push_c, pop_c;
  maddr_t stk_top;
  logic   stk_full, stk_empty;

`ifdef MICROSEQ_LOOP_EN
  logic [7:0] cnt_q, cnt_d;
`endif

  microseq_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (MICROADDR_W)
  ) u_stack (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_c),
    .pop_i       (pop_c),
    .push_data_i (cur_addr + maddr_t'(1)),
    .top_o       (stk_top),
    .sp_o        (sp),
    .full_o      (stk_full),
    .empty_o     (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      fault_code_q <= FAULT_NONE;
      fault_q      <= 1'b0;
`ifdef MICROSEQ_LOOP_EN
      cnt_q        <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      fault_code_q <= fault_code_d;
      fault_q      <= (state_d == ST_FAULT);
`ifdef MICROSEQ_LOOP_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  // Decode; reset, stall and FAULT all fall through to the NONE defaults.
  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    cmd_c        = CMD_NONE;
    load_addr_c  = '0;
    push_c       = 1'b0;
    pop_c        = 1'b0;
`ifdef MICROSEQ_LOOP_EN
    cnt_d        = cnt_q;
`endif
    if (!reset && (state_q == ST_RUN) && !stall) begin
      case (seq_op)
        SEQ_NEXT: cmd_c = CMD_INC;
        SEQ_JUMP: begin
          cmd_c       = CMD_LOAD;
          load_addr_c = target;
        end
        SEQ_JCOND: begin
          if (flags[cond_sel] ^ cond_inv) begin
            cmd_c       = CMD_LOAD;
            load_addr_c = target;
          end else begin
            cmd_c = CMD_INC;
          end
        end
        SEQ_DISPATCH: begin
          cmd_c       = CMD_LOAD;
          load_addr_c = maddr_t'(DISPATCH_BASE + (maddr_t'(opcode) << DISPATCH_SHIFT));
        end
        SEQ_CALL: begin
          if (!stk_full) begin
            push_c      = 1'b1;
            cmd_c       = CMD_LOAD;
            load_addr_c = target;
          end else begin
            fault_code_d = FAULT_OVERFLOW;
            state_d      = ST_FAULT;
          end
        end
        SEQ_RET: begin
          if (!stk_empty) begin
            pop_c       = 1'b1;
            cmd_c       = CMD_LOAD;
            load_addr_c = stk_top;
          end else begin
            fault_code_d = FAULT_UNDERFLOW;
            state_d      = ST_FAULT;
          end
        end
`ifdef MICROSEQ_LOOP_EN
        SEQ_LDCNT: begin
          cnt_d = target[7:0];
          cmd_c = CMD_INC;
        end
        SEQ_DJNZ: begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_d != 8'd0) begin
            cmd_c       = CMD_LOAD;
            load_addr_c = target;
          end else begin
            cmd_c = CMD_INC;
          end
        end
`endif
        default: cmd_c = CMD_INC;
      endcase
    end
  end

  assign cmd        = cmd_c;
  assign load_addr  = load_addr_c;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_microseq_ctrl.sv
// Self-checking bench for microseq_ctrl against a queue-based behavioural model.
module tb_microseq_ctrl;
  import microseq_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  seq_op_e     seq_op;
  logic [10:0] target, cur_addr;
  logic [2:0]  cond_sel;
  logic        cond_inv, stall;
  logic [7:0]  flags, opcode;

  cmd_e        cmd, cmd2;
  logic [10:0] load_addr, load_addr2;
  logic [2:0]  sp, sp2;
  logic        fault, fault2;
  logic [1:0]  fault_code, fault_code2;

  int n_tests = 0;
  int n_fail  = 0;

  int m_stack[$];
  bit m_fault;
  int m_fc;
  int m_cnt;

  microseq_ctrl dut (
    .clk(clk), .reset(reset), .seq_op(seq_op), .target(target),
    .cond_sel(cond_sel), .cond_inv(cond_inv), .flags(flags), .opcode(opcode),
    .stall(stall), .cur_addr(cur_addr), .cmd(cmd), .load_addr(load_addr),
    .sp(sp), .fault(fault), .fault_code(fault_code)
  );

  microseq_ctrl #(.STACK_DEPTH(4), .DISPATCH_BASE(11'h7F8), .DISPATCH_SHIFT(3)) dut2 (
    .clk(clk), .reset(reset), .seq_op(seq_op), .target(target),
    .cond_sel(cond_sel), .cond_inv(cond_inv), .flags(flags), .opcode(opcode),
    .stall(stall), .cur_addr(cur_addr), .cmd(cmd2), .load_addr(load_addr2),
    .sp(sp2), .fault(fault2), .fault_code(fault_code2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected zero-latency outputs for both instances from the current model state.
  task automatic model_expect(output cmd_e ec, output int ea, output int ea2);
    int nc;
    ec = CMD_NONE; ea = 0; ea2 = -1;
    if (!reset && !m_fault && !stall) begin
      case (seq_op)
        SEQ_JUMP: begin ec = CMD_LOAD; ea = target; end
        SEQ_JCOND: begin
          if ((((flags >> cond_sel) & 1) ^ cond_inv) != 0) begin ec = CMD_LOAD; ea = target; end
          else ec = CMD_INC;
        end
        SEQ_DISPATCH: begin
          ec = CMD_LOAD;
          ea  = (1024 + opcode * 4) % 2048;
          ea2 = (2040 + opcode * 8) % 2048;
        end
        SEQ_CALL: if (m_stack.size() < 4) begin ec = CMD_LOAD; ea = target; end
        SEQ_RET:  if (m_stack.size() > 0) begin ec = CMD_LOAD; ea = m_stack[$]; end
`ifdef MICROSEQ_LOOP_EN
        SEQ_DJNZ: begin
          nc = (m_cnt + 255) % 256;
          if (nc != 0) begin ec = CMD_LOAD; ea = target; end
          else ec = CMD_INC;
        end
`endif
        default: ec = CMD_INC;
      endcase
    end
    if (ea2 < 0) ea2 = ea;
  endtask

  // Advance one clock and update the model with the inputs seen at that edge.
  task automatic tick();
    int d;
    @(posedge clk);
    if (reset) begin
      m_stack = {}; m_fault = 0; m_fc = 0; m_cnt = 0;
    end else if (!m_fault && !stall) begin
      case (seq_op)
        SEQ_CALL:
          if (m_stack.size() < 4) m_stack.push_back((cur_addr + 1) % 2048);
          else begin m_fault = 1; m_fc = 1; end
        SEQ_RET:
          if (m_stack.size() > 0) d = m_stack.pop_back();
          else begin m_fault = 1; m_fc = 2; end
`ifdef MICROSEQ_LOOP_EN
        SEQ_LDCNT: m_cnt = target % 256;
        SEQ_DJNZ:  m_cnt = (m_cnt + 255) % 256;
`endif
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic set_in(input seq_op_e op, input int tgt, input int ca, input bit st);
    seq_op = op; target = 11'(tgt); cur_addr = 11'(ca); stall = st;
  endtask

  task automatic test_reset();
    cmd_e ec; int ea, ea2;
    reset = 1'b1; cond_sel = 3'd0; cond_inv = 1'b0; flags = 8'h00; opcode = 8'h00;
    set_in(SEQ_JUMP, 11'h123, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (cmd !== CMD_NONE || load_addr !== 11'h000) begin
        n_fail++;
        $display("FAIL reset_comb cycle %0d: cmd=%0d addr=%h, expected cmd=0 addr=000", i, cmd, load_addr);
      end
      tick();
    end
    n_tests++;
    if (sp !== 3'd0 || fault !== 1'b0 || fault_code !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: sp=%0d fault=%0b code=%0d, expected 0/0/0", sp, fault, fault_code);
    end
    reset = 1'b0;
    model_expect(ec, ea, ea2);
    #1;
    n_tests++;
    if (cmd !== ec || load_addr !== 11'(ea)) begin
      n_fail++;
      $display("FAIL reset_release: cmd=%0d addr=%h, expected cmd=%0d addr=%h", cmd, load_addr, ec, 11'(ea));
    end
    tick();
  endtask

  task automatic test_jcond();
    cmd_e ec; int ea, ea2;
    // Directed pair first, then random flag/select/invert combinations.
    for (int i = 0; i < 24; i++) begin
      if (i < 2) begin
        flags = 8'h08; cond_sel = 3'd3; cond_inv = 1'(i);
      end else begin
        flags = 8'($urandom); cond_sel = 3'($urandom); cond_inv = 1'($urandom);
      end
      set_in(SEQ_JCOND, (i < 2) ? 11'h050 : int'($urandom_range(0, 2047)), 0, 1'b0);
      #1;
      model_expect(ec, ea, ea2);
      n_tests++;
      if (cmd !== ec || load_addr !== 11'(ea)) begin
        n_fail++;
        $display("FAIL jcond %0d: cmd=%0d addr=%h, expected cmd=%0d addr=%h", i, cmd, load_addr, ec, 11'(ea));
      end
      tick();
    end
  endtask

  task automatic test_dispatch();
    cmd_e ec; int ea, ea2;
    for (int i = 0; i < 16; i++) begin
      opcode = (i == 0) ? 8'h3F : (i == 1) ? 8'hFF : 8'($urandom);
      set_in(SEQ_DISPATCH, 0, 0, 1'b0);
      #1;
      model_expect(ec, ea, ea2);
      n_tests++;
      if (cmd !== ec || load_addr !== 11'(ea) || cmd2 !== ec || load_addr2 !== 11'(ea2)) begin
        n_fail++;
        $display("FAIL dispatch op=%h: addr=%h addr2=%h, expected %h %h", opcode, load_addr, load_addr2, 11'(ea), 11'(ea2));
      end
      tick();
    end
  endtask

  task automatic test_call_ret();
    seq_op_e ops[4] = '{SEQ_CALL, SEQ_CALL, SEQ_RET, SEQ_RET};
    int      tg[4]  = '{'h200, 'h300, 0, 0};
    int      ca[4]  = '{'h010, 'h205, 'h301, 'h206};
    int      el[4]  = '{'h200, 'h300, 'h206, 'h011};
    int      es[4]  = '{1, 2, 1, 0};
    for (int i = 0; i < 4; i++) begin
      set_in(ops[i], tg[i], ca[i], 1'b0);
      #1;
      n_tests++;
      if (cmd !== CMD_LOAD || load_addr !== 11'(el[i])) begin
        n_fail++;
        $display("FAIL call_ret_load %0d: cmd=%0d addr=%h, expected cmd=2 addr=%h", i, cmd, load_addr, 11'(el[i]));
      end
      tick();
      n_tests++;
      if (sp !== 3'(es[i])) begin
        n_fail++;
        $display("FAIL call_ret_sp %0d: sp=%0d, expected %0d", i, sp, es[i]);
      end
    end
    // Return address wraps at the top of the address space.
    set_in(SEQ_CALL, 'h100, 'h7FF, 1'b0); #1; tick();
    set_in(SEQ_RET, 0, 'h100, 1'b0); #1;
    n_tests++;
    if (cmd !== CMD_LOAD || load_addr !== 11'h000) begin
      n_fail++;
      $display("FAIL call_wrap: cmd=%0d addr=%h, expected cmd=2 addr=000", cmd, load_addr);
    end
    tick();
  endtask

  task automatic test_faults();
    for (int i = 0; i < 5; i++) begin
      set_in(SEQ_CALL, 'h040 + i, 'h020 + i, 1'b0);
      #1;
      if (i == 4) begin
        n_tests++;
        if (cmd !== CMD_NONE || load_addr !== 11'h000) begin
          n_fail++;
          $display("FAIL overflow_cmd: cmd=%0d addr=%h, expected cmd=0 addr=000", cmd, load_addr);
        end
      end
      tick();
    end
    n_tests++;
    if (fault !== 1'b1 || fault_code !== 2'd1 || sp !== 3'd4) begin
      n_fail++;
      $display("FAIL overflow_state: fault=%0b code=%0d sp=%0d, expected 1/1/4", fault, fault_code, sp);
    end
    set_in(SEQ_RET, 0, 0, 1'b0); #1;
    n_tests++;
    if (cmd !== CMD_NONE || load_addr !== 11'h000) begin
      n_fail++;
      $display("FAIL fault_ret: cmd=%0d addr=%h, expected cmd=0 addr=000", cmd, load_addr);
    end
    tick();
    n_tests++;
    if (sp !== 3'd4 || fault !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_frozen: sp=%0d fault=%0b, expected 4/1", sp, fault);
    end
    reset = 1'b1; #1; tick(); reset = 1'b0;
    n_tests++;
    if (sp !== 3'd0 || fault !== 1'b0 || fault_code !== 2'd0) begin
      n_fail++;
      $display("FAIL fault_reset: sp=%0d fault=%0b code=%0d, expected 0/0/0", sp, fault, fault_code);
    end
    set_in(SEQ_RET, 0, 0, 1'b0); #1;
    n_tests++;
    if (cmd !== CMD_NONE) begin
      n_fail++;
      $display("FAIL underflow_cmd: cmd=%0d, expected 0", cmd);
    end
    tick();
    n_tests++;
    if (fault !== 1'b1 || fault_code !== 2'd2 || sp !== 3'd0) begin
      n_fail++;
      $display("FAIL underflow_state: fault=%0b code=%0d sp=%0d, expected 1/2/0", fault, fault_code, sp);
    end
    reset = 1'b1; #1; tick(); reset = 1'b0;
  endtask

  task automatic test_loop();
    seq_op_e ops[5] = '{SEQ_LDCNT, SEQ_DJNZ, SEQ_DJNZ, SEQ_DJNZ, SEQ_DJNZ};
    bit      st[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef MICROSEQ_LOOP_EN
    cmd_e    ec[5]  = '{CMD_INC, CMD_LOAD, CMD_LOAD, CMD_NONE, CMD_INC};
`else
    cmd_e    ec[5]  = '{CMD_INC, CMD_INC, CMD_INC, CMD_NONE, CMD_INC};
`endif
    for (int i = 0; i < 5; i++) begin
      set_in(ops[i], (i == 0) ? 'h003 : 'h080, 'h010, st[i]);
      #1;
      n_tests++;
      if (cmd !== ec[i] || load_addr !== ((ec[i] == CMD_LOAD) ? 11'h080 : 11'h000)) begin
        n_fail++;
        $display("FAIL loop %0d: cmd=%0d addr=%h, expected cmd=%0d", i, cmd, load_addr, ec[i]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    cmd_e ec; int ea, ea2;
    int   fault_age = 0;
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 99) < 3) || (fault_age > 3);
      flags    = 8'($urandom);
      cond_sel = 3'($urandom);
      cond_inv = 1'($urandom);
      opcode   = 8'($urandom);
      set_in(seq_op_e'($urandom_range(0, 7)), int'($urandom_range(0, 2047)),
             int'($urandom_range(0, 2047)), ($urandom_range(0, 99) < 20));
      #1;
      model_expect(ec, ea, ea2);
      n_tests++;
      if (cmd !== ec || load_addr !== 11'(ea) || cmd2 !== ec || load_addr2 !== 11'(ea2)) begin
        n_fail++;
        $display("FAIL random_comb %0d op=%0d: cmd=%0d addr=%h addr2=%h, expected cmd=%0d addr=%h addr2=%h",
                 i, seq_op, cmd, load_addr, load_addr2, ec, 11'(ea), 11'(ea2));
      end
      tick();
      fault_age = m_fault ? fault_age + 1 : 0;
      n_tests++;
      if (sp !== 3'(m_stack.size()) || fault !== m_fault || fault_code !== 2'(m_fc) ||
          sp2 !== 3'(m_stack.size()) || fault2 !== m_fault) begin
        n_fail++;
        $display("FAIL random_state %0d: sp=%0d fault=%0b code=%0d, expected sp=%0d fault=%0b code=%0d",
                 i, sp, fault, fault_code, m_stack.size(), m_fault, m_fc);
      end
    end
  endtask

  initial begin
    m_fault = 0; m_fc = 0; m_cnt = 0;
    test_reset();
    test_jcond();
    test_dispatch();
    test_call_ret();
    test_faults();
    test_loop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
